// File: rtl/leitor_7seg.sv
// Recovers unidade/dezena/estado values from a multiplexed 7-segment drive and hands out frames.
// Optional LEITOR_7SEG_ERRCNT_EN adds a saturating 8-bit illegal-glyph counter output err_cnt.
module leitor_7seg #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [2:0] dig_sel,
  output logic [3:0] unid_out,
  output logic [1:0] dez_out,
  output logic [1:0] estado_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       glyph_err,
  output logic       overrun
`ifdef LEITOR_7SEG_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;
  localparam logic [7:0] STABLE_N   = 8'(STABLE_CYCLES);

  // {legal-pattern, value}; legality per digit position is applied separately
  function automatic logic [4:0] glyph_decode(input logic [6:0] g);
    case (g)
      7'h3F:   return 5'h10;
      7'h06:   return 5'h11;
      7'h5B:   return 5'h12;
      7'h4F:   return 5'h13;
      7'h66:   return 5'h14;
      7'h6D:   return 5'h15;
      7'h7D:   return 5'h16;
      7'h07:   return 5'h17;
      7'h7F:   return 5'h18;
      7'h6F:   return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

  logic [6:0] seg_norm;
  logic [6:0] seg_q, held_seg_q, held_seg_d;
  logic [2:0] sel_q, held_sel_q, held_sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic [2:0] mask_q, mask_d;
  logic [3:0] unid_q, unid_d, ounid_q, ounid_d;
  logic [1:0] dez_q, dez_d, odez_q, odez_d;
  logic [1:0] est_q, est_d, oest_q, oest_d;
  logic       valid_q, valid_d, gerr_q, gerr_d, ovr_q, ovr_d;
  logic       sel_onehot, same_glyph, start_run, cap_en, cap_legal, cap_ok;
  logic       frame_full, frame_load;
  logic [4:0] dec;

  assign seg_norm = SEG_ACTIVE_LOW ? ~seg_in : seg_in;

  // Glyph tracking. A change seen in CAPTURE or HOLD restarts the run on the same
  // cycle, so every run of identical samples is timed the same way.
  always_comb begin
    sel_onehot = (sel_q == 3'b001) || (sel_q == 3'b010) || (sel_q == 3'b100);
    same_glyph = (seg_q == held_seg_q) && (sel_q == held_sel_q);
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_seg_d = held_seg_q;
    held_sel_d = held_sel_q;
    start_run  = 1'b0;
    cap_en     = 1'b0;
    case (state_q)
      ST_IDLE:   start_run = 1'b1;
      ST_SETTLE: begin
        if (same_glyph) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d >= STABLE_N) state_d = ST_CAPTURE;
        end else begin
          start_run = 1'b1;
        end
      end
      ST_CAPTURE: begin
        cap_en = 1'b1;
        if (same_glyph) state_d = ST_HOLD;
        else            start_run = 1'b1;
      end
      default: if (!same_glyph) start_run = 1'b1;
    endcase
    if (start_run) begin
      if (sel_onehot) begin
        held_seg_d = seg_q;
        held_sel_d = sel_q;
        cnt_d      = 8'd1;
        state_d    = (STABLE_N <= 8'd1) ? ST_CAPTURE : ST_SETTLE;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    dec        = glyph_decode(held_seg_q);
    cap_legal  = dec[4] && (held_sel_q[0] || (dec[3:0] <= 4'd3));
    cap_ok     = cap_en && cap_legal;
    gerr_d     = cap_en && !cap_legal;
    frame_full = &mask_q;
    frame_load = frame_full && (!valid_q || out_ready);
    mask_d     = (frame_full ? 3'b000 : mask_q) | (cap_ok ? held_sel_q : 3'b000);
    unid_d     = (cap_ok && held_sel_q[0]) ? dec[3:0] : unid_q;
    dez_d      = (cap_ok && held_sel_q[1]) ? dec[1:0] : dez_q;
    est_d      = (cap_ok && held_sel_q[2]) ? dec[1:0] : est_q;
    ounid_d    = frame_load ? unid_q : ounid_q;
    odez_d     = frame_load ? dez_q  : odez_q;
    oest_d     = frame_load ? est_q  : oest_q;
    valid_d    = frame_load ? 1'b1 : (valid_q && !out_ready);
    ovr_d      = ovr_q || (frame_full && valid_q && !out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= '0;
      sel_q      <= '0;
      held_seg_q <= '0;
      held_sel_q <= '0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      unid_q     <= '0;
      dez_q      <= '0;
      est_q      <= '0;
      ounid_q    <= '0;
      odez_q     <= '0;
      oest_q     <= '0;
      valid_q    <= 1'b0;
      gerr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      seg_q      <= seg_norm;
      sel_q      <= dig_sel;
      held_seg_q <= held_seg_d;
      held_sel_q <= held_sel_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      mask_q     <= mask_d;
      unid_q     <= unid_d;
      dez_q      <= dez_d;
      est_q      <= est_d;
      ounid_q    <= ounid_d;
      odez_q     <= odez_d;
      oest_q     <= oest_d;
      valid_q    <= valid_d;
      gerr_q     <= gerr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign unid_out   = ounid_q;
  assign dez_out    = odez_q;
  assign estado_out = oest_q;
  assign out_valid  = valid_q;
  assign glyph_err  = gerr_q;
  assign overrun    = ovr_q;

`ifdef LEITOR_7SEG_ERRCNT_EN
  logic [7:0] ecnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ecnt_q <= '0;
    else if (gerr_d && ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
  end

  assign err_cnt = ecnt_q;
`endif

endmodule

// File: tb/tb_leitor_7seg.sv
// Bench for leitor_7seg: directed scenarios plus random stimulus against a run-length reference model.
module tb_leitor_7seg;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg, seg_n;
  logic [2:0] sel;
  logic       rdy;
  logic [3:0] u_unid, a_unid;
  logic [1:0] u_dez, u_est, a_dez, a_est;
  logic       u_vld, u_gerr, u_ovr, a_vld, a_gerr, a_ovr;
`ifdef LEITOR_7SEG_ERRCNT_EN
  logic [7:0] u_ecnt, a_ecnt;
`endif

  always #5 clk = ~clk;
  assign seg_n = ~seg;

  leitor_7seg #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg), .dig_sel(sel),
    .unid_out(u_unid), .dez_out(u_dez), .estado_out(u_est),
    .out_valid(u_vld), .out_ready(rdy), .glyph_err(u_gerr), .overrun(u_ovr)
`ifdef LEITOR_7SEG_ERRCNT_EN
    , .err_cnt(u_ecnt)
`endif
  );

  leitor_7seg #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_n), .dig_sel(sel),
    .unid_out(a_unid), .dez_out(a_dez), .estado_out(a_est),
    .out_valid(a_vld), .out_ready(rdy), .glyph_err(a_gerr), .overrun(a_ovr)
`ifdef LEITOR_7SEG_ERRCNT_EN
    , .err_cnt(a_ecnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [6:0] glyph_tab [10];

  // reference model: captures are scheduled from run lengths of identical samples
  typedef struct { int due; logic [6:0] g; logic [2:0] s; } cap_t;
  cap_t       capq[$];
  int         edge_n, run_len, m_ecnt;
  logic [9:0] prev_smp;
  logic [3:0] md_u, m_u;
  logic [1:0] md_d, md_e, m_d, m_e;
  logic [2:0] m_mask;
  logic       m_vld, m_gerr, m_ovr;

  int         mon_nv, mon_ng, amon_nv, amon_ng;
  logic [7:0] mon_fr, amon_fr;

  function automatic int glyph_idx(input logic [6:0] g);
    for (int i = 0; i < 10; i++) if (glyph_tab[i] == g) return i;
    return -1;
  endfunction

  function automatic bit onehot3(input logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
  endfunction

  task automatic model_reset();
    capq.delete();
    edge_n = 0; run_len = 0; prev_smp = '0; m_ecnt = 0;
    md_u = '0; md_d = '0; md_e = '0; m_u = '0; m_d = '0; m_e = '0;
    m_mask = '0; m_vld = 1'b0; m_gerr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step();
    cap_t c;
    int   idx;
    bit   legal;
    edge_n++;
    if (m_mask == 3'b111) begin
      if (!m_vld || rdy) begin
        m_u = md_u; m_d = md_d; m_e = md_e; m_vld = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      m_mask = 3'b000;
    end else if (m_vld && rdy) begin
      m_vld = 1'b0;
    end
    m_gerr = 1'b0;
    if (capq.size() > 0 && capq[0].due == edge_n) begin
      c = capq.pop_front();
      idx = glyph_idx(c.g);
      legal = (idx >= 0) && ((c.s == 3'b001) ? (idx <= 9) : (idx <= 3));
      if (legal) begin
        if (c.s == 3'b001) md_u = 4'(idx);
        if (c.s == 3'b010) md_d = 2'(idx);
        if (c.s == 3'b100) md_e = 2'(idx);
        m_mask = m_mask | c.s;
      end else begin
        m_gerr = 1'b1;
        if (m_ecnt < 255) m_ecnt++;
      end
    end
    if ({sel, seg} == prev_smp && onehot3(sel)) run_len++;
    else run_len = onehot3(sel) ? 1 : 0;
    prev_smp = {sel, seg};
    if (run_len == S) capq.push_back('{edge_n + 2, seg, sel});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    seg = '0; sel = '0; rdy = 1'b0; rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_mon();
    mon_nv = 0; mon_ng = 0; amon_nv = 0; amon_ng = 0; mon_fr = '0; amon_fr = '0;
  endtask

  task automatic hold(input logic [2:0] s, input logic [6:0] g, input int n);
    sel = s; seg = g;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (u_vld) begin mon_nv++; mon_fr = {u_unid, u_dez, u_est}; end
      if (u_gerr) mon_ng++;
      if (a_vld) begin amon_nv++; amon_fr = {a_unid, a_dez, a_est}; end
      if (a_gerr) amon_ng++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({u_unid, u_dez, u_est, u_vld, u_gerr, u_ovr} !== 12'h000) begin
      failures++; $display("FAIL reset_outs got=%h exp=000", {u_unid, u_dez, u_est, u_vld, u_gerr, u_ovr});
    end
    checks++;
    if ({a_unid, a_dez, a_est, a_vld, a_gerr, a_ovr} !== 12'h000) begin
      failures++; $display("FAIL reset_outs_al got=%h exp=000", {a_unid, a_dez, a_est, a_vld, a_gerr, a_ovr});
    end
`ifdef LEITOR_7SEG_ERRCNT_EN
    checks++;
    if (u_ecnt !== 8'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", u_ecnt); end
`endif
  endtask

  task automatic test_frame();
    do_reset(); clear_mon(); rdy = 1'b1;
    hold(3'b001, 7'h6F, 6);
    hold(3'b010, 7'h06, 6);
    hold(3'b100, 7'h5B, 6);
    hold(3'b000, 7'h00, 6);
    checks++;
    if (mon_nv !== 1) begin failures++; $display("FAIL frame_valid_cycles got=%0d exp=1", mon_nv); end
    checks++;
    if (mon_fr !== {4'd9, 2'd1, 2'd2}) begin failures++; $display("FAIL frame_value got=%h exp=%h", mon_fr, {4'd9, 2'd1, 2'd2}); end
    checks++;
    if (mon_ng !== 0) begin failures++; $display("FAIL frame_gerr got=%0d exp=0", mon_ng); end
    checks++;
    if (u_vld !== 1'b0) begin failures++; $display("FAIL frame_accepted got=%b exp=0", u_vld); end
  endtask

  task automatic test_bounce();
    do_reset(); clear_mon(); rdy = 1'b1;
    for (int i = 0; i < 10; i++) hold(3'b001, (i % 2 == 1) ? 7'h6F : 7'h7F, 2);
    hold(3'b000, 7'h00, 6);
    checks++;
    if (mon_nv !== 0) begin failures++; $display("FAIL bounce_valid got=%0d exp=0", mon_nv); end
    checks++;
    if (mon_ng !== 0) begin failures++; $display("FAIL bounce_gerr got=%0d exp=0", mon_ng); end
  endtask

  task automatic test_illegal();
    do_reset(); clear_mon(); rdy = 1'b1;
    hold(3'b010, 7'h66, 6);
    hold(3'b000, 7'h00, 3);
    checks++;
    if (mon_ng !== 1) begin failures++; $display("FAIL illegal_gerr_pulses got=%0d exp=1", mon_ng); end
    hold(3'b001, 7'h06, 6);
    hold(3'b100, 7'h4F, 6);
    hold(3'b000, 7'h00, 4);
    checks++;
    if (mon_nv !== 0) begin failures++; $display("FAIL illegal_no_frame got=%0d exp=0", mon_nv); end
    hold(3'b010, 7'h5B, 6);
    hold(3'b000, 7'h00, 4);
    checks++;
    if (mon_nv !== 1 || mon_fr !== {4'd1, 2'd2, 2'd3}) begin
      failures++; $display("FAIL illegal_then_legal got=%0d/%h exp=1/%h", mon_nv, mon_fr, {4'd1, 2'd2, 2'd3});
    end
  endtask

  task automatic test_overrun();
    int unstable;
    do_reset(); clear_mon(); rdy = 1'b0; unstable = 0;
    hold(3'b001, 7'h4F, 6);
    hold(3'b010, 7'h5B, 6);
    hold(3'b100, 7'h06, 6);
    hold(3'b000, 7'h00, 3);
    checks++;
    if ({u_vld, u_ovr, u_unid, u_dez, u_est} !== {1'b1, 1'b0, 4'd3, 2'd2, 2'd1}) begin
      failures++; $display("FAIL overrun_first got=%h exp=%h", {u_vld, u_ovr, u_unid, u_dez, u_est}, {1'b1, 1'b0, 4'd3, 2'd2, 2'd1});
    end
    sel = 3'b001; seg = 7'h07;
    for (int i = 0; i < 24; i++) begin
      if (i == 6)  begin sel = 3'b010; seg = 7'h3F; end
      if (i == 12) begin sel = 3'b100; seg = 7'h4F; end
      if (i == 18) begin sel = 3'b000; seg = 7'h00; end
      cyc();
      if ({u_vld, u_unid, u_dez, u_est} !== {1'b1, 4'd3, 2'd2, 2'd1}) unstable++;
    end
    checks++;
    if (unstable !== 0) begin failures++; $display("FAIL overrun_held_cycles_changed got=%0d exp=0", unstable); end
    checks++;
    if (u_ovr !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", u_ovr); end
    rdy = 1'b1;
    cyc();
    checks++;
    if ({u_vld, u_ovr} !== 2'b01) begin failures++; $display("FAIL overrun_accept got=%b exp=01", {u_vld, u_ovr}); end
  endtask

  task automatic test_reset_mid();
    clear_mon(); rdy = 1'b1;
    hold(3'b001, 7'h6D, 6);
    hold(3'b010, 7'h4F, 6);
    hold(3'b000, 7'h00, 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({u_unid, u_dez, u_est, u_vld, u_gerr, u_ovr} !== 12'h000) begin
      failures++; $display("FAIL midreset_outs got=%h exp=000", {u_unid, u_dez, u_est, u_vld, u_gerr, u_ovr});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hold(3'b100, 7'h06, 6);
    hold(3'b000, 7'h00, 5);
    checks++;
    if (mon_nv !== 0) begin failures++; $display("FAIL midreset_no_frame got=%0d exp=0", mon_nv); end
  endtask

  task automatic test_active_low();
    do_reset(); clear_mon(); rdy = 1'b1;
    hold(3'b001, 7'h3F, 6);
    hold(3'b010, 7'h3F, 6);
    hold(3'b100, 7'h3F, 6);
    hold(3'b000, 7'h00, 4);
    checks++;
    if (amon_nv !== 1 || amon_fr !== 8'h00 || amon_ng !== 0) begin
      failures++; $display("FAIL active_low_frame got=%0d/%h/%0d exp=1/00/0", amon_nv, amon_fr, amon_ng);
    end
    checks++;
    if (mon_nv !== 1 || mon_fr !== 8'h00) begin
      failures++; $display("FAIL active_high_zero_frame got=%0d/%h exp=1/00", mon_nv, mon_fr);
    end
  endtask

  task automatic test_random();
    logic [2:0]  s;
    logic [6:0]  g;
    logic [11:0] exp_v;
    int          len, rbias, k;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      s = 3'b000;
      else if (k == 1) s = 3'b011;
      else if (k < 5)  s = 3'b001;
      else if (k < 8)  s = 3'b010;
      else             s = 3'b100;
      g = ($urandom_range(0, 4) != 0) ? glyph_tab[$urandom_range(0, 9)] : 7'($urandom);
      len = $urandom_range(1, 8);
      rbias = $urandom_range(0, 4);
      sel = s; seg = g;
      for (int c = 0; c < len; c++) begin
        rdy = ($urandom_range(0, 3) < rbias);
        cyc();
        exp_v = {m_u, m_d, m_e, m_vld, m_gerr, m_ovr};
        checks++;
        if ({u_unid, u_dez, u_est, u_vld, u_gerr, u_ovr} !== exp_v) begin
          failures++; $display("FAIL random_outs edge=%0d got=%h exp=%h", edge_n, {u_unid, u_dez, u_est, u_vld, u_gerr, u_ovr}, exp_v);
        end
        checks++;
        if ({a_unid, a_dez, a_est, a_vld, a_gerr, a_ovr} !== exp_v) begin
          failures++; $display("FAIL random_outs_al edge=%0d got=%h exp=%h", edge_n, {a_unid, a_dez, a_est, a_vld, a_gerr, a_ovr}, exp_v);
        end
`ifdef LEITOR_7SEG_ERRCNT_EN
        checks++;
        if (u_ecnt !== 8'(m_ecnt)) begin failures++; $display("FAIL random_errcnt got=%0d exp=%0d", u_ecnt, m_ecnt); end
`endif
      end
    end
  endtask

`ifdef LEITOR_7SEG_ERRCNT_EN
  task automatic test_errcnt();
    do_reset(); clear_mon(); rdy = 1'b1;
    for (int i = 0; i < 300; i++) hold(3'b010, (i % 2 == 1) ? 7'h66 : 7'h6D, 5);
    hold(3'b000, 7'h00, 3);
    checks++;
    if (mon_ng !== 300) begin failures++; $display("FAIL errcnt_pulses got=%0d exp=300", mon_ng); end
    checks++;
    if (u_ecnt !== 8'd255 || a_ecnt !== 8'd255) begin
      failures++; $display("FAIL errcnt_saturate got=%0d/%0d exp=255/255", u_ecnt, a_ecnt);
    end
  endtask
`endif

  initial begin
    glyph_tab[0] = 7'h3F; glyph_tab[1] = 7'h06; glyph_tab[2] = 7'h5B; glyph_tab[3] = 7'h4F;
    glyph_tab[4] = 7'h66; glyph_tab[5] = 7'h6D; glyph_tab[6] = 7'h7D; glyph_tab[7] = 7'h07;
    glyph_tab[8] = 7'h7F; glyph_tab[9] = 7'h6F;
    clear_mon();
    test_reset();
    test_frame();
    test_bounce();
    test_illegal();
    test_overrun();
    test_reset_mid();
    test_active_low();
    test_random();
`ifdef LEITOR_7SEG_ERRCNT_EN
    test_errcnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
